// File: rtl/timing_engine_seq.sv
// -----------------------------------------------------------------------------
// timing_engine_seq
//
// Radio timing-engine sequencer. Converts the synchronized radio enable and
// RX-enable requests into the timed radio front-end controls: the PLL is
// powered first, lock is awaited with a bounded timeout, and a programmable
// post-lock settle time (tArstFs) elapses before the radio is enabled.
//
// Ports:
//   clk                system clock
//   reset              synchronous, active-high reset
//   radioEnableSynced  radio enable request (level, already synchronized)
//   radioRxEnSynced    mode select latched at session start: 1=RX, 0=TX
//   pllSettled         PLL lock indication (level)
//   tArstFs            post-lock settle time in cycles, sampled on ARST entry
//   pllEnable          PLL power/enable (PLL_WAIT, ARST, ACTIVE)
//   radioEnable        radio enabled (ACTIVE only)
//   radioRxEn          radio in RX mode (ACTIVE and latched RX mode)
//   busy               sequencer is not idle
//   pllTimeoutErr      PLL failed to lock within PLL_TIMEOUT cycles
//
// All outputs are registered. They are decoded from the next state so that
// each output is valid in the same cycle its state becomes the registered
// state.
// -----------------------------------------------------------------------------
module timing_engine_seq #(
   parameter int SIZE_SPISLAVE_T_ARSTFS = 8,
   parameter int SIZE_PLL_TIMEOUT       = 8,
   parameter int PLL_TIMEOUT            = 200
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              radioEnableSynced,
   input  logic                              radioRxEnSynced,
   input  logic                              pllSettled,
   input  logic [SIZE_SPISLAVE_T_ARSTFS-1:0] tArstFs,
   output logic                              pllEnable,
   output logic                              radioEnable,
   output logic                              radioRxEn,
   output logic                              busy,
   output logic                              pllTimeoutErr
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PLL_WAIT = 3'd1,
      ST_ARST     = 3'd2,
      ST_ACTIVE   = 3'd3,
      ST_ERROR    = 3'd4
   } state_t;

   // Last value of the lock-wait counter before giving up; pllSettled is
   // therefore sampled on exactly PLL_TIMEOUT cycles in PLL_WAIT.
   localparam logic [SIZE_PLL_TIMEOUT-1:0] WAIT_LAST = SIZE_PLL_TIMEOUT'(PLL_TIMEOUT - 1);

   state_t                              state_reg, state_next;
   logic [SIZE_PLL_TIMEOUT-1:0]         wait_cnt_reg, wait_cnt_next;
   logic [SIZE_SPISLAVE_T_ARSTFS-1:0]   arst_cnt_reg, arst_cnt_next;
   logic                                rx_mode_reg, rx_mode_next;

   logic pll_enable_next;
   logic radio_enable_next;
   logic radio_rx_en_next;
   logic busy_next;
   logic pll_timeout_err_next;

   // ---------------------------------------------------------------------
   // Next-state and counter logic. A dropped request returns to IDLE from
   // any active state and takes priority over lock/count events.
   // ---------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      arst_cnt_next = arst_cnt_reg;
      rx_mode_next  = rx_mode_reg;

      case (state_reg)
         ST_IDLE: begin
            if (radioEnableSynced) begin
               state_next    = ST_PLL_WAIT;
               rx_mode_next  = radioRxEnSynced;
               wait_cnt_next = '0;
            end
         end

         ST_PLL_WAIT: begin
            if (!radioEnableSynced) begin
               state_next = ST_IDLE;
            end else if (pllSettled) begin
               state_next    = ST_ARST;
               arst_cnt_next = tArstFs;
            end else if (wait_cnt_reg == WAIT_LAST) begin
               state_next = ST_ERROR;
            end else begin
               wait_cnt_next = wait_cnt_reg + 1'b1;
            end
         end

         ST_ARST: begin
            if (!radioEnableSynced) begin
               state_next = ST_IDLE;
            end else if (!pllSettled) begin
               // Lock lost during settle: start a fresh lock wait.
               state_next    = ST_PLL_WAIT;
               wait_cnt_next = '0;
            end else if (arst_cnt_reg == '0) begin
               state_next = ST_ACTIVE;
            end else begin
               arst_cnt_next = arst_cnt_reg - 1'b1;
            end
         end

         ST_ACTIVE: begin
            if (!radioEnableSynced) begin
               state_next = ST_IDLE;
            end else if (!pllSettled) begin
               state_next    = ST_PLL_WAIT;
               wait_cnt_next = '0;
            end
         end

         ST_ERROR: begin
            // No automatic retry: the requester must drop and re-raise.
            if (!radioEnableSynced) begin
               state_next = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Output decode from the next state, registered below.
   // ---------------------------------------------------------------------
   always_comb begin
      pll_enable_next      = 1'b0;
      radio_enable_next    = 1'b0;
      radio_rx_en_next     = 1'b0;
      busy_next            = 1'b0;
      pll_timeout_err_next = 1'b0;

      case (state_next)
         ST_PLL_WAIT: begin
            pll_enable_next = 1'b1;
            busy_next       = 1'b1;
         end
         ST_ARST: begin
            pll_enable_next = 1'b1;
            busy_next       = 1'b1;
         end
         ST_ACTIVE: begin
            pll_enable_next   = 1'b1;
            radio_enable_next = 1'b1;
            radio_rx_en_next  = rx_mode_next;
            busy_next         = 1'b1;
         end
         ST_ERROR: begin
            busy_next            = 1'b1;
            pll_timeout_err_next = 1'b1;
         end
         default: begin
            busy_next = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // State, counters and registered outputs.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         wait_cnt_reg  <= '0;
         arst_cnt_reg  <= '0;
         rx_mode_reg   <= 1'b0;
         pllEnable     <= 1'b0;
         radioEnable   <= 1'b0;
         radioRxEn     <= 1'b0;
         busy          <= 1'b0;
         pllTimeoutErr <= 1'b0;
      end else begin
         state_reg     <= state_next;
         wait_cnt_reg  <= wait_cnt_next;
         arst_cnt_reg  <= arst_cnt_next;
         rx_mode_reg   <= rx_mode_next;
         pllEnable     <= pll_enable_next;
         radioEnable   <= radio_enable_next;
         radioRxEn     <= radio_rx_en_next;
         busy          <= busy_next;
         pllTimeoutErr <= pll_timeout_err_next;
      end
   end

endmodule

// File: tb/tb_timing_engine_seq.sv
// -----------------------------------------------------------------------------
// tb_timing_engine_seq
//
// Directed bench for timing_engine_seq (PLL_TIMEOUT=4). Outputs are sampled
// 1 time unit after each rising edge and compared as the packed vector
// {pllEnable, radioEnable, radioRxEn, busy, pllTimeoutErr}.
// "Cycle 0" of a scenario is the cycle in which the request is raised; the
// value observed after the k-th following edge is the cycle-k output.
// -----------------------------------------------------------------------------
module tb_timing_engine_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       radioEnableSynced;
   logic       radioRxEnSynced;
   logic       pllSettled;
   logic [7:0] tArstFs;
   logic       pllEnable;
   logic       radioEnable;
   logic       radioRxEn;
   logic       busy;
   logic       pllTimeoutErr;

   int tests = 0;
   int fails = 0;

   // Expected output patterns {pll, radio, rx, busy, err}
   localparam logic [4:0] O_IDLE   = 5'b00000;
   localparam logic [4:0] O_WAIT   = 5'b10010;  // PLL_WAIT or ARST
   localparam logic [4:0] O_ACT_RX = 5'b11110;
   localparam logic [4:0] O_ACT_TX = 5'b11010;
   localparam logic [4:0] O_ERR    = 5'b00011;

   timing_engine_seq #(
      .SIZE_SPISLAVE_T_ARSTFS(8),
      .SIZE_PLL_TIMEOUT      (8),
      .PLL_TIMEOUT           (4)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .radioEnableSynced(radioEnableSynced),
      .radioRxEnSynced  (radioRxEnSynced),
      .pllSettled       (pllSettled),
      .tArstFs          (tArstFs),
      .pllEnable        (pllEnable),
      .radioEnable      (radioEnable),
      .radioRxEn        (radioRxEn),
      .busy             (busy),
      .pllTimeoutErr    (pllTimeoutErr)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [4:0] exp);
      logic [4:0] obs;
      obs = {pllEnable, radioEnable, radioRxEn, busy, pllTimeoutErr};
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
      $display("[TB] t=%0t %s out=%b exp=%b", $time, tag, obs, exp);
   endtask

   initial begin
      reset             = 1'b1;
      radioEnableSynced = 1'b0;
      radioRxEnSynced   = 1'b0;
      pllSettled        = 1'b0;
      tArstFs           = 8'd0;

      // ---- Reset and idle hold ----
      step();
      step();
      chk("reset", O_IDLE);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("idle_%0d", i), O_IDLE);
      end

      // ---- RX session, tArstFs=5: radio at cycle 8 ----
      tArstFs         = 8'd5;
      radioRxEnSynced = 1'b1;
      pllSettled      = 1'b1;
      radioEnableSynced = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         step();
         chk($sformatf("rx5_c%0d", c), (c < 8) ? O_WAIT : O_ACT_RX);
      end
      radioEnableSynced = 1'b0;
      step();
      chk("rx5_drop", O_IDLE);

      // ---- RX session, tArstFs=0: radio at cycle 3 ----
      tArstFs = 8'd0;
      radioEnableSynced = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         step();
         chk($sformatf("rx0_c%0d", c), (c < 3) ? O_WAIT : O_ACT_RX);
      end
      // Mode input toggled during ACTIVE is ignored
      radioRxEnSynced = 1'b0;
      step();
      chk("rx_toggle_a", O_ACT_RX);
      radioRxEnSynced = 1'b1;
      step();
      radioRxEnSynced = 1'b0;
      step();
      chk("rx_toggle_b", O_ACT_RX);
      // tArstFs change during ACTIVE has no effect either
      tArstFs = 8'd9;
      step();
      chk("tarst_in_active", O_ACT_RX);
      // Reset during ACTIVE
      reset = 1'b1;
      step();
      chk("reset_active", O_IDLE);
      radioEnableSynced = 1'b0;
      reset = 1'b0;
      step();
      chk("post_reset", O_IDLE);

      // ---- PLL timeout: ERROR at cycle 5 ----
      pllSettled = 1'b0;
      radioEnableSynced = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         step();
         chk($sformatf("tmo_c%0d", c), (c < 5) ? O_WAIT : O_ERR);
      end
      // Lock arriving in ERROR does not restart the sequence
      pllSettled = 1'b1;
      step();
      chk("err_hold", O_ERR);
      radioEnableSynced = 1'b0;
      step();
      chk("err_drop", O_IDLE);

      // ---- TX session, tArstFs=3, relock after a one-cycle lock loss ----
      radioRxEnSynced = 1'b0;
      pllSettled      = 1'b1;
      tArstFs         = 8'd3;
      radioEnableSynced = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         step();
         chk($sformatf("tx3_c%0d", c), (c < 6) ? O_WAIT : O_ACT_TX);
      end
      pllSettled = 1'b0;
      step();
      chk("relock_pllwait", O_WAIT);
      pllSettled = 1'b1;
      step();
      chk("relock_arst0", O_WAIT);
      // Settle time was captured on ARST entry; a change now is ignored
      tArstFs = 8'd0;
      for (int j = 1; j <= 4; j++) begin
         step();
         chk($sformatf("relock_a%0d", j), (j < 4) ? O_WAIT : O_ACT_TX);
      end
      radioEnableSynced = 1'b0;
      step();
      chk("tx_drop", O_IDLE);

      // ---- Drop request on the cycle arstCnt reaches 0 ----
      tArstFs = 8'd2;
      radioEnableSynced = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         step();
         chk($sformatf("abort_c%0d", c), O_WAIT);
      end
      radioEnableSynced = 1'b0;
      for (int c = 5; c <= 7; c++) begin
         step();
         chk($sformatf("abort_c%0d", c), O_IDLE);
      end

      // ---- Drop request on the same cycle lock arrives in PLL_WAIT ----
      pllSettled = 1'b0;
      radioEnableSynced = 1'b1;
      step();
      chk("prio_wait", O_WAIT);
      pllSettled = 1'b1;
      radioEnableSynced = 1'b0;
      step();
      chk("prio_idle", O_IDLE);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
